// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: decode-side redirect/hazard controls, instruction-memory
// port and the IF/ID register outputs presented to decode.
interface fetch_stage_if #(
   parameter int unsigned WIDTH = 32
);

   // Hazard and redirect controls from decode
   logic             stall;
   logic             flush;
   logic             PCSrc;
   logic             AddrMode;
   logic [WIDTH-1:0] ImmExt;
   logic [WIDTH-1:0] RD1;

   // Instruction memory
   logic [WIDTH-1:0] imem_addr;
   logic [WIDTH-1:0] imem_rdata;

   // IF/ID register outputs
   logic [WIDTH-1:0] pc_f;
   logic [WIDTH-1:0] instr_d;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] pc_plus4_d;
   logic             valid_d;
   logic             misaligned_d;

   // Fetch stage side
   modport master (
      input  stall, flush, PCSrc, AddrMode, ImmExt, RD1, imem_rdata,
      output imem_addr, pc_f, instr_d, pc_d, pc_plus4_d, valid_d, misaligned_d
   );

   // Decode / memory side
   modport slave (
      output stall, flush, PCSrc, AddrMode, ImmExt, RD1, imem_rdata,
      input  imem_addr, pc_f, instr_d, pc_d, pc_plus4_d, valid_d, misaligned_d
   );

endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Holds the fetch PC,
// drives the instruction-memory address and accepts redirects resolved in
// decode, with stall and flush support.
module fetch_stage #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC  = '0,
   parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013)
) (
   input logic            clk,
   input logic            rst,
   fetch_stage_if.master  bus
);

   localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

   // State registers
   logic [WIDTH-1:0] pc_q, pc_n;
   logic [WIDTH-1:0] instr_q, instr_n;
   logic [WIDTH-1:0] pcd_q, pcd_n;
   logic [WIDTH-1:0] pcp4_q, pcp4_n;
   logic             valid_q, valid_n;
   logic             mis_q, mis_n;

   // Redirect datapath
   logic [WIDTH-1:0] pc_seq;
   logic [WIDTH-1:0] tgt_base;
   logic [WIDTH-1:0] tgt_sum;
   logic [WIDTH-1:0] tgt;
   logic [WIDTH-1:0] tgt_pc;
   logic             take;
   logic             tgt_mis;

   // Sequential PC and redirect target computation
   always_comb begin
      pc_seq   = pc_q + PC_STEP;
      tgt_base = bus.AddrMode ? bus.RD1 : pcd_q;
      tgt_sum  = tgt_base + bus.ImmExt;
      // JALR clears bit 0 of the computed address
      tgt      = bus.AddrMode ? {tgt_sum[WIDTH-1:1], 1'b0} : tgt_sum;
      tgt_mis  = tgt[1];
      // A misaligned target is still followed, word-aligned
      tgt_pc   = tgt_mis ? {tgt[WIDTH-1:2], 2'b00} : tgt;
      // Redirects from a bubble in decode are spurious
      take     = bus.PCSrc & valid_q;
   end

   // Next-state selection: redirect > flush > stall > sequential fetch
   always_comb begin
      pc_n    = pc_q;
      instr_n = instr_q;
      pcd_n   = pcd_q;
      pcp4_n  = pcp4_q;
      valid_n = valid_q;
      mis_n   = take & tgt_mis;
      if (take) begin
         pc_n    = tgt_pc;
         instr_n = NOP_INSTR;
         valid_n = 1'b0;
      end else if (bus.flush) begin
         instr_n = NOP_INSTR;
         valid_n = 1'b0;
         if (!bus.stall) begin
            pc_n = pc_seq;
         end
      end else if (!bus.stall) begin
         pc_n    = pc_seq;
         instr_n = bus.imem_rdata;
         pcd_n   = pc_q;
         pcp4_n  = pc_seq;
         valid_n = 1'b1;
      end
   end

   // PC and IF/ID register with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         pcd_q   <= '0;
         pcp4_q  <= '0;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         pc_q    <= pc_n;
         instr_q <= instr_n;
         pcd_q   <= pcd_n;
         pcp4_q  <= pcp4_n;
         valid_q <= valid_n;
         mis_q   <= mis_n;
      end
   end

   // Output drive; memory address follows the PC with no delay
   always_comb begin
      bus.imem_addr    = pc_q;
      bus.pc_f         = pc_q;
      bus.instr_d      = instr_q;
      bus.pc_d         = pcd_q;
      bus.pc_plus4_d   = pcp4_q;
      bus.valid_d      = valid_q;
      bus.misaligned_d = mis_q;
   end

endmodule
